// File: rtl/score_digit_ctrl_if.sv
// Signal bundle between the readout controller and its environment: beam position,
// value-load handshake and the glyph renderer outputs.
interface score_digit_ctrl_if;
  logic       pix_en;
  logic [9:0] x;
  logic [8:0] y;
  logic       frame_start;
  logic [13:0] value_in;
  logic       value_load;
  logic       value_busy;
  logic       glyph_en;
  logic [5:0] glyph_num;
  logic [5:0] glyph_pos;
  logic [9:0] glyph_lx;
  logic [8:0] glyph_ly;

  modport master (
    output pix_en, x, y, frame_start, value_in, value_load,
    input  value_busy, glyph_en, glyph_num, glyph_pos, glyph_lx, glyph_ly
  );

  modport slave (
    input  pix_en, x, y, frame_start, value_in, value_load,
    output value_busy, glyph_en, glyph_num, glyph_pos, glyph_lx, glyph_ly
  );
endinterface

// File: rtl/score_digit_ctrl.sv
// Multi-digit numeric readout sequencer: double-dabble BCD conversion, frame-aligned
// digit commit and per-pixel slot tracking with leading-zero blanking.
module score_digit_ctrl #(
  parameter int DIGITS   = 4,
  parameter int GLYPH_W  = 60,
  parameter int GLYPH_H  = 100,
  parameter int ORIGIN_X = 200,
  parameter int ORIGIN_Y = 190
) (
  input logic               clk,
  input logic               rst_n,
  score_digit_ctrl_if.slave bus
);

  localparam int BIN_W = 14;
  localparam int BCD_W = 4 * DIGITS;

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam logic [BIN_W-1:0] MAX_VAL  = BIN_W'(pow10(DIGITS) - 1);
  localparam logic [3:0]       CNT_LAST = 4'(BIN_W - 1);
  localparam logic [9:0]       X_LO     = 10'(ORIGIN_X);
  localparam logic [9:0]       X_HI     = 10'(ORIGIN_X + DIGITS * GLYPH_W);
  localparam logic [8:0]       Y_LO     = 9'(ORIGIN_Y);
  localparam logic [8:0]       Y_HI     = 9'(ORIGIN_Y + GLYPH_H);
  localparam logic [9:0]       COL_LAST = 10'(GLYPH_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [BIN_W-1:0] bin_q, bin_nxt;
  logic [BCD_W-1:0] bcd_q, bcd_nxt, bcd_adj;
  logic [3:0]       cnt_q, cnt_nxt;
  logic [BCD_W-1:0] shadow_q, active_q;
  logic             shadow_we;

  logic             in_region;
  logic [9:0]       col_q, col_nxt;
  logic [5:0]       slot_q, slot_nxt;
  logic [DIGITS-1:0] blank;
  logic             zero_run;
  logic [3:0]       cur_digit;
  logic             cur_blank;
  logic             slot_ok;
  logic             vis;

  logic             glyph_en_q;
  logic [5:0]       glyph_num_q;
  logic [5:0]       glyph_pos_q;
  logic [9:0]       glyph_lx_q;
  logic [8:0]       glyph_ly_q;

  // Double-dabble correction: every nibble of 5 or more gets +3 before the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_nxt = state;
    bin_nxt   = bin_q;
    bcd_nxt   = bcd_q;
    cnt_nxt   = cnt_q;
    shadow_we = 1'b0;
    case (state)
      IDLE: begin
        if (bus.value_load) begin
          bin_nxt   = (bus.value_in > MAX_VAL) ? MAX_VAL : bus.value_in;
          bcd_nxt   = '0;
          cnt_nxt   = '0;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_nxt, bin_nxt} = {bcd_adj, bin_q} << 1;
        cnt_nxt = cnt_q + 4'd1;
        // The last shift also performs the DONE work, so busy lasts exactly BIN_W cycles.
        if (cnt_q == CNT_LAST) begin
          shadow_we = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else begin
      state <= state_nxt;
      bin_q <= bin_nxt;
      bcd_q <= bcd_nxt;
      cnt_q <= cnt_nxt;
    end
  end

  // Active reads the pre-edge shadow, so a same-edge write waits for the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      if (shadow_we) shadow_q <= bcd_nxt;
      if (bus.frame_start) active_q <= shadow_q;
    end
  end

  assign bus.value_busy = (state == SHIFT);

  assign in_region = (bus.x >= X_LO) && (bus.x < X_HI) &&
                     (bus.y >= Y_LO) && (bus.y < Y_HI);

  always_comb begin
    col_nxt  = col_q;
    slot_nxt = slot_q;
    if (bus.x == X_LO) begin
      col_nxt  = '0;
      slot_nxt = '0;
    end else if (in_region) begin
      if (col_q == COL_LAST) begin
        col_nxt  = '0;
        slot_nxt = slot_q + 6'd1;
      end else begin
        col_nxt = col_q + 10'd1;
      end
    end
  end

  // Slot 0 holds the most significant digit; the last slot always shows.
  always_comb begin
    zero_run = 1'b1;
    blank    = '0;
    for (int i = 0; i < DIGITS; i++) begin
      zero_run = zero_run & (active_q[BCD_W-4-4*i +: 4] == 4'd0);
      blank[i] = zero_run & (i != DIGITS - 1);
    end
  end

  always_comb begin
    cur_digit = 4'd0;
    cur_blank = 1'b0;
    slot_ok   = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (slot_nxt == 6'(i)) begin
        cur_digit = active_q[BCD_W-4-4*i +: 4];
        cur_blank = blank[i];
        slot_ok   = 1'b1;
      end
    end
  end

  assign vis = in_region && slot_ok && !cur_blank;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      slot_q      <= '0;
      glyph_en_q  <= 1'b0;
      glyph_num_q <= 6'h3F;
      glyph_pos_q <= '0;
      glyph_lx_q  <= '0;
      glyph_ly_q  <= '0;
    end else if (bus.pix_en) begin
      col_q       <= col_nxt;
      slot_q      <= slot_nxt;
      glyph_en_q  <= vis;
      glyph_num_q <= vis ? {2'b00, cur_digit} : 6'h3F;
      glyph_pos_q <= slot_nxt;
      glyph_lx_q  <= col_nxt;
      glyph_ly_q  <= bus.y - Y_LO;
    end
  end

  assign bus.glyph_en  = glyph_en_q;
  assign bus.glyph_num = glyph_num_q;
  assign bus.glyph_pos = glyph_pos_q;
  assign bus.glyph_lx  = glyph_lx_q;
  assign bus.glyph_ly  = glyph_ly_q;

endmodule

// File: doc/score_digit_ctrl.md
# score_digit_ctrl

Controller that sequences the digit glyph renderer for a multi-digit numeric readout (score/counter) on the VGA frame. It accepts a binary value through a load/busy handshake and converts it to BCD with a sequential double-dabble engine. It commits the new digits only at frame start, so no frame shows a partial update. Per pixel, it tracks which digit slot the beam is in and drives the renderer's digit, slot and glyph-local coordinates, with leading-zero blanking.

## Interface
- `DIGITS`, 4, number of decimal digit slots; slot 0 is leftmost (most significant).
- `GLYPH_W`, 60, glyph cell width in pixels.
- `GLYPH_H`, 100, glyph cell height in pixels.
- `ORIGIN_X`, 200, x of the left edge of slot 0; 10 bits.
- `ORIGIN_Y`, 190, y of the top edge of the readout; 9 bits.

Ports:
- `clk`  in  1  single system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pix_en`  in  1  pixel strobe; `x`/`y` advance by one pixel per strobe.
- `x`  in  10  current beam x.
- `y`  in  9  current beam y.
- `frame_start`  in  1  one-cycle pulse at the start of vertical blanking.
- `value_in`  in  14  binary value to display.
- `value_load`  in  1  load request, sampled when `value_busy`=0.
- `value_busy`  out  1  conversion in progress.
- `glyph_en`  out  1  beam is inside the readout and the current digit is visible.
- `glyph_num`  out  6  digit 0–9 for the renderer; 6'h3F when not enabled.
- `glyph_pos`  out  6  current slot index.
- `glyph_lx`  out  10  x within the current glyph cell, 0..GLYPH_W-1.
- `glyph_ly`  out  9  y within the readout, 0..GLYPH_H-1.

## Operation
- Reset (asynchronous, `rst_n`=0):
  - All outputs go to 0, except `glyph_num`=6'h3F.
  - Shadow and active BCD registers clear to 0; the FSM goes to IDLE.
  - Reset during a conversion aborts it; nothing is written to shadow.
- Conversion FSM has three states: IDLE, SHIFT, DONE.
  - IDLE: if `value_load`=1, capture `min(value_in, 10^DIGITS-1)`, clear the 4·DIGITS-bit BCD accumulator and go to SHIFT. Shift counter starts at 0.
  - SHIFT: each cycle, add 3 to every BCD nibble ≥5, then shift {bcd, bin} left by one. Exit after 14 shifts.
  - DONE: the DONE transition is merged into the 14th SHIFT edge. That edge writes the corrected final BCD into shadow and returns the FSM to IDLE.
  - `value_load` while `value_busy`=1 is ignored (no queueing).
- Frame commit: on `frame_start`, active ← shadow.
  - If a shadow write and `frame_start` fall on the same edge, active takes the old shadow. The new value appears on the next frame.
- Region: the readout is x in [ORIGIN_X, ORIGIN_X+DIGITS·GLYPH_W) and y in [ORIGIN_Y, ORIGIN_Y+GLYPH_H).
- Slot tracking uses counters, not a divider. On each `pix_en`:
  - x==ORIGIN_X: col=0, slot=0.
  - Otherwise, inside the region: col+1; when col would reach GLYPH_W, col=0 and slot+1.
  - Outside the region, the counters hold.
- Leading-zero blanking: a slot is blanked if it and every slot to its left hold 0. Slot DIGITS-1 is never blanked.
- Outputs per `pix_en`:
  - `glyph_en` = in-region AND not blanked.
  - `glyph_num` = active digit[slot] if `glyph_en`, else 6'h3F.
  - `glyph_pos` = slot, `glyph_lx` = col, `glyph_ly` = y−ORIGIN_Y (low 9 bits).
- Without `pix_en`, all glyph outputs hold.

## Timing
- Handshake: `value_busy` rises on the edge that accepts `value_load` (E0).
  - Shifts happen on E1..E14; E14 writes shadow and drops `value_busy`, so busy is high for exactly 14 cycles.
  - The earliest next accept is E15.
- Glyph outputs are registered with one cycle of latency: they describe the `x`/`y` sampled on the prior `pix_en` edge.
- Active digits change only on the edge that samples `frame_start`, and are stable for the whole visible frame.

## Test plan
- Reset mid-conversion: load 1234, assert `rst_n`=0 at E5 → busy=0, active=shadow=0000, `glyph_num`=6'h3F; a later frame_start still displays 0.
- Load 1234, frame_start at E20:
  - busy high for E1–E14; shadow=1,2,3,4 after E14.
  - Scan row y=ORIGIN_Y+10: x=200 → next cycle pos 0, num 1, lx 0; x=259 → lx 59; x=260 → pos 1, num 2, lx 0; x=439 → pos 3, num 4.
- Load 0042, frame_start → slots 0–1 have `glyph_en`=0 and num 6'h3F; slots 2–3 show 4 and 2. Load 0 → only slot 3 shows 0.
- Load 16383 → displayed 9999 (saturation). Pulse `value_load` again at E3 while busy → ignored; shadow still 9999 after E14.
- Shadow write on the same edge as frame_start → that frame shows the old value; the next frame_start shows the new one.
- x=199 or x=440, or y=ORIGIN_Y+100 → `glyph_en`=0. `pix_en` held low for 5 cycles → outputs unchanged.
